// File: rtl/mem_fifo_pkg.sv
// Shared defaults and helpers for the memory-backed FIFO controller.
package mem_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned DEFAULT_DEPTH = 48;

  // Ceiling log2; returns the bit count needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_fifo_out_stage.sv
// Two-slot output buffer: slot 0 is the head; shifts on dequeue and captures
// returning read data into the lowest slot that is free after the shift.
module mem_fifo_out_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             deq_ready,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] cap_data,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_bits,
  output logic [1:0]       out_count
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       cnt_shift;
  logic             deq_fire;

  assign deq_valid = (cnt_q != 2'd0);
  assign deq_bits  = slot0_q;
  assign out_count = cnt_q;
  assign deq_fire  = deq_valid & deq_ready;

  // Next-state: shift first, then place captured data in the lowest free slot.
  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    cnt_shift = cnt_q - {1'b0, deq_fire};
    if (deq_fire) slot0_d = slot1_q;
    if (cap_en) begin
      if (cnt_shift == 2'd0) slot0_d = cap_data;
      else                   slot1_d = cap_data;
    end
    cnt_d = cnt_shift + {1'b0, cap_en};
  end

  // Slot registers; the issue rule upstream keeps occupancy at most two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      assert (!(cap_en && (cnt_shift == 2'd2)))
        else $error("out_stage overflow");
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_1r1w_fifo.sv
// Ready/valid FIFO controller in front of an external 1R1W memory macro with
// one-cycle read latency; reads are prefetched into a 2-slot output stage.
module mem_1r1w_fifo
  import mem_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = clog2(DEPTH),
  parameter int unsigned CNT_W  = clog2(DEPTH + 3)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_count_q, mem_count_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [1:0]        out_count;
  logic [2:0]        pending;
  logic              enq_fire, deq_fire, rd_issue;

  assign enq_ready = (mem_count_q < CNT_W'(DEPTH));
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Entries already headed for the output stage, net of this cycle's dequeue.
  assign pending  = {1'b0, out_count} + {2'b00, rd_inflight_q} - {2'b00, deq_fire};
  assign rd_issue = (mem_count_q != '0) && (pending < 3'd2);

  assign W0_en   = enq_fire;
  assign W0_addr = wr_ptr_q;
  assign W0_data = enq_bits;
  assign R0_en   = rd_issue;
  assign R0_addr = rd_ptr_q;

  assign count = mem_count_q + CNT_W'(rd_inflight_q) + CNT_W'(out_count);

  // Pointer wrap at DEPTH-1 and occupancy update from enqueue/read-issue.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_inflight_d = rd_issue;
    if (enq_fire)
      wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
    if (rd_issue)
      rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
    mem_count_d = mem_count_q + CNT_W'(enq_fire) - CNT_W'(rd_issue);
  end

  // Pointer and occupancy registers; reset also drops any in-flight read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  mem_fifo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clock     (clock),
    .reset     (reset),
    .deq_ready (deq_ready),
    .cap_en    (rd_inflight_q),
    .cap_data  (R0_data),
    .deq_valid (deq_valid),
    .deq_bits  (deq_bits),
    .out_count (out_count)
  );

endmodule

// File: doc/mem_1r1w_fifo.md
Name: mem_1r1w_fifo

Overview:
- Single-clock ready/valid FIFO controller that drives an external generated 1R1W memory macro (DEPTH x WIDTH, write port W0, read port R0, 1-cycle registered read latency).
- Sits directly upstream of the macro: owns write/read pointers and occupancy, and prefetches reads into a 2-entry output stage so the consumer sees a zero-bubble ready/valid stream.
- The parent ties the macro's W0_clk/R0_clk to clock.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 48, memory entries; any value >= 2, not required to be a power of two.
- ADDR_W, clog2(DEPTH) = 6, memory address width.
- CNT_W, clog2(DEPTH+3) = 6, width of the count output.

Ports:
- clock  in  1  sole clock; all state is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  memory has a free entry.
- enq_bits  in  WIDTH  enqueue data.
- deq_valid  out  1  output slot 0 holds data.
- deq_ready  in  1  consumer accepts.
- deq_bits  out  WIDTH  head data (slot 0).
- count  out  CNT_W  total entries held: mem_count + rd_inflight + out_count.
- W0_addr  out  ADDR_W  memory write address (wr_ptr).
- W0_en  out  1  memory write enable (= enq fire).
- W0_data  out  WIDTH  = enq_bits.
- R0_addr  out  ADDR_W  memory read address (rd_ptr).
- R0_en  out  1  memory read issue.
- R0_data  in  WIDTH  memory read data, valid the cycle after R0_en.

Behaviour:
- Fire events: enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
- Reset values, asserted asynchronously:
  - wr_ptr = rd_ptr = 0, mem_count = 0, rd_inflight = 0, out_count = 0.
  - enq_ready = 1, deq_valid = 0, count = 0, W0_en = 0, R0_en = 0.
  - deq_bits = 0 (slot registers cleared).
- Memory contents are not cleared. A reset mid-operation discards all held data and any in-flight read; R0_data arriving the cycle after reset deasserts is ignored.
- Enqueue:
  - enq_ready = (mem_count < DEPTH); it is a pure function of registered state and does not depend on deq_ready.
  - On enq_fire: W0_en = 1, W0_addr = wr_ptr, wr_ptr advances with wrap DEPTH-1 -> 0, mem_count += 1.
- Read issue:
  - R0_en = (mem_count > 0) & (out_count + rd_inflight - deq_fire < 2).
  - On issue: R0_addr = rd_ptr, rd_ptr wraps DEPTH-1 -> 0, mem_count -= 1, rd_inflight <= 1.
  - mem_count counts only entries written at prior edges, so a read never targets the address written in the same cycle. There is no same-address read/write collision.
- Simultaneous events: enq_fire and read issue in the same cycle leave mem_count unchanged.
- Output stage: two slots, slot 0 = head.
  - When rd_inflight = 1, R0_data is captured at the end of that cycle into the lowest free slot, computed after deq_fire shifts slot 1 into slot 0.
  - deq_valid = (out_count > 0); deq_bits = slot0.
  - out_count never exceeds 2 (guaranteed by the issue rule). Overflow is an assertion failure.
- Latency:
  - Enqueue into an empty FIFO, enq_fire at cycle t: read issued at t+1, R0_data at t+2, deq_valid at t+3.
  - Steady state: with enq_valid and deq_ready held high, one beat per cycle with no bubbles.
- No bypass path from enq to deq. Total capacity = DEPTH + 2.
- Arithmetic: pointers are ADDR_W bits with explicit compare-to-DEPTH-1 wrap (not modulo 2^N). Counters are saturation-free; the invariants above guarantee range.

Decomposition:
- Shared package mem_fifo_pkg: WIDTH/DEPTH defaults and a clog2 function for ADDR_W/CNT_W.
- One sub-module, mem_fifo_out_stage: the 2-slot output buffer with shift-on-deq and capture-on-read logic.
- Pointer and count logic stays in the top module.
- The bench instantiates mem_1r1w alongside (not inside) this block.

Test Plan:
- Reset, then idle -> enq_ready=1, deq_valid=0, count=0, R0_en=0 for 10 cycles.
- Single enq of 0xDEADBEEF_00000001 at cycle t with deq_ready=0 -> R0_en at t+1 (R0_addr=0), deq_valid at t+3 with deq_bits=0xDEADBEEF_00000001, count=1 from t+1 onward.
- Fill with deq_ready=0 and values 0..49 -> enq_ready drops after 50 accepted beats (48 in memory + 2 slots), count=50. Then deq_ready=1 -> 0..49 emerge in order, wr_ptr/rd_ptr wrap 47->0 observed.
- Streaming: enq_valid=deq_ready=1 for 200 cycles with incrementing data -> after 3-cycle fill, one beat per cycle, in order, count stays 1..3.
- Random enq_valid/deq_ready at 50% for 5000 cycles -> scoreboard match, count equals model, no R0_addr==W0_addr with both enables high.
- Assert reset for 1 cycle while count=20 and a read is in flight -> all outputs return to reset values immediately, next 3 enqueued values emerge first with no stale data.
